// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: one aligned fetch block per handshake, slot mask, redirect epoch, IDLE/FAULT holding.
// Latency: redirects and sequential/BTB next-PC appear on PcDate the cycle after they are taken.
// Backpressure: PcStop/!IcacheReady hold the block; ROB/predecode redirects are taken regardless.
module fetch_pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter int                FETCH_W    = 4,
  parameter int                INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] ENTRY_PC   = ADDR_W'(32'h1c000000),
  parameter int                EPOCH_W    = 3,
  parameter int                BOOT_DELAY = 2
) (
  input  logic                       Clk,
  input  logic                       Rest,
  input  logic                       PcStop,
  input  logic                       IcacheReady,
  input  logic                       BtbPredictAble,
  input  logic [ADDR_W-1:0]          BtbPredictPc,
  input  logic [$clog2(FETCH_W)-1:0] BtbPredictSlot,
  input  logic                       PreReDirAble,
  input  logic [ADDR_W-1:0]          PreReDirPc,
  input  logic                       RobReDirAble,
  input  logic [ADDR_W-1:0]          RobReDirPc,
  input  logic                       RobIdleAble,
  input  logic                       WakeUp,
  output logic                       PcAble,
  output logic [ADDR_W-1:0]          PcDate,
  output logic [FETCH_W-1:0]         PcMask,
  output logic [EPOCH_W-1:0]         PcEpoch,
  output logic                       PcAdef
);

  localparam int LOG_IB = $clog2(INST_BYTES);
  localparam int LOG_FW = $clog2(FETCH_W);
  localparam int BLK    = FETCH_W * INST_BYTES;
  localparam int CNT_W  = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_M   = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] BLK_M     = ADDR_W'(BLK - 1);
  localparam logic [ADDR_W-1:0] BLK_SZ    = ADDR_W'(BLK);
  localparam logic [CNT_W-1:0]  BOOT_LAST = CNT_W'(BOOT_DELAY - 1);

  typedef enum logic [1:0] {BOOT, RUN, IDLE, FAULT} pcState_t;

  pcState_t          state;
  logic [CNT_W-1:0]  bootCnt;

  logic [LOG_FW-1:0] pcOff;
  logic              btbHit;
  logic              fire;
  logic [ADDR_W-1:0] seqPc;
  logic [ADDR_W-1:0] robPcAl, prePcAl, btbPcAl;
  logic              robMis, preMis, btbMis;

  assign pcOff = PcDate[LOG_IB +: LOG_FW];
  assign fire  = PcAble & IcacheReady & ~PcStop;
  assign seqPc = (PcDate & ~BLK_M) + BLK_SZ;

  // A BTB slot before the block's entry offset cannot belong to this fetch, so it is ignored.
  assign btbHit = BtbPredictAble & (BtbPredictSlot >= pcOff);

  // Targets are forced to instruction alignment; the dropped bits flag an ADEF fault.
  assign robPcAl = RobReDirPc & ~ALIGN_M;
  assign prePcAl = PreReDirPc & ~ALIGN_M;
  assign btbPcAl = BtbPredictPc & ~ALIGN_M;
  assign robMis  = |(RobReDirPc & ALIGN_M);
  assign preMis  = |(PreReDirPc & ALIGN_M);
  assign btbMis  = |(BtbPredictPc & ALIGN_M);

  // Slot mask: slots from the entry offset up to and including a taken-predicted branch.
  always_comb begin
    PcMask = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      PcMask[i] = (LOG_FW'(i) >= pcOff) && (!btbHit || (LOG_FW'(i) <= BtbPredictSlot));
    end
  end

  // Control FSM with registered PC, valid, epoch and fault outputs.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state   <= BOOT;
      bootCnt <= '0;
      PcAble  <= 1'b0;
      PcDate  <= ENTRY_PC;
      PcEpoch <= '0;
      PcAdef  <= 1'b0;
    end else begin
      // Boot delay runs independently of redirects, which only retarget the PC during BOOT.
      if (state == BOOT) begin
        if (bootCnt == BOOT_LAST) begin
          state  <= RUN;
          PcAble <= 1'b1;
        end else begin
          bootCnt <= bootCnt + CNT_W'(1);
        end
      end

      if (RobReDirAble) begin
        PcDate  <= robPcAl;
        PcAdef  <= robMis;
        PcEpoch <= PcEpoch + EPOCH_W'(1);
        if (state != BOOT) begin
          if (RobIdleAble) begin
            state  <= IDLE;
            PcAble <= 1'b0;
          end else begin
            state  <= RUN;
            PcAble <= 1'b1;
          end
        end
      end else if (PreReDirAble && (state == BOOT || state == RUN)) begin
        PcDate  <= prePcAl;
        PcAdef  <= preMis;
        PcEpoch <= PcEpoch + EPOCH_W'(1);
      end else if (fire && state == RUN) begin
        if (PcAdef) begin
          // The faulting block has been handed over; freeze until the ROB steers us away.
          state  <= FAULT;
          PcAble <= 1'b0;
        end else if (btbHit) begin
          PcDate <= btbPcAl;
          PcAdef <= btbMis;
        end else begin
          PcDate <= seqPc;
          PcAdef <= 1'b0;
        end
      end else if (state == IDLE && WakeUp) begin
        state  <= RUN;
        PcAble <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

  logic        Clk;
  logic        Rest;
  logic        PcStop;
  logic        IcacheReady;
  logic        BtbPredictAble;
  logic [31:0] BtbPredictPc;
  logic [1:0]  BtbPredictSlot;
  logic        PreReDirAble;
  logic [31:0] PreReDirPc;
  logic        RobReDirAble;
  logic [31:0] RobReDirPc;
  logic        RobIdleAble;
  logic        WakeUp;
  logic        PcAble;
  logic [31:0] PcDate;
  logic [3:0]  PcMask;
  logic [2:0]  PcEpoch;
  logic        PcAdef;

  int checks = 0;
  int errors = 0;

  fetch_pc_gen dut (
    .Clk(Clk), .Rest(Rest), .PcStop(PcStop), .IcacheReady(IcacheReady),
    .BtbPredictAble(BtbPredictAble), .BtbPredictPc(BtbPredictPc), .BtbPredictSlot(BtbPredictSlot),
    .PreReDirAble(PreReDirAble), .PreReDirPc(PreReDirPc),
    .RobReDirAble(RobReDirAble), .RobReDirPc(RobReDirPc), .RobIdleAble(RobIdleAble),
    .WakeUp(WakeUp), .PcAble(PcAble), .PcDate(PcDate), .PcMask(PcMask),
    .PcEpoch(PcEpoch), .PcAdef(PcAdef)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rest = 1'b1; PcStop = 1'b0; IcacheReady = 1'b1;
    BtbPredictAble = 1'b0; BtbPredictPc = '0; BtbPredictSlot = '0;
    PreReDirAble = 1'b0; PreReDirPc = '0; RobReDirAble = 1'b0; RobReDirPc = '0;
    RobIdleAble = 1'b0; WakeUp = 1'b0;
    tick(); tick();
    checks++; if (PcAble !== 1'b0) begin errors++; $display("FAIL rst_able got=%b exp=0", PcAble); end
    checks++; if (PcDate !== 32'h1c000000) begin errors++; $display("FAIL rst_pc got=%h exp=1c000000", PcDate); end
    checks++; if (PcEpoch !== 3'd0) begin errors++; $display("FAIL rst_epoch got=%0d exp=0", PcEpoch); end
    checks++; if (PcAdef !== 1'b0) begin errors++; $display("FAIL rst_adef got=%b exp=0", PcAdef); end
    checks++; if (PcMask !== 4'b1111) begin errors++; $display("FAIL rst_mask got=%b exp=1111", PcMask); end
    Rest = 1'b0;
    tick();
    checks++; if (PcAble !== 1'b0) begin errors++; $display("FAIL boot_c1_able got=%b exp=0", PcAble); end
    tick();
    checks++; if (PcAble !== 1'b1) begin errors++; $display("FAIL boot_c2_able got=%b exp=1", PcAble); end
    checks++; if (PcDate !== 32'h1c000000) begin errors++; $display("FAIL boot_pc got=%h exp=1c000000", PcDate); end
    checks++; if (PcMask !== 4'b1111) begin errors++; $display("FAIL boot_mask got=%b exp=1111", PcMask); end
    tick();
    checks++; if (PcDate !== 32'h1c000010) begin errors++; $display("FAIL seq_pc got=%h exp=1c000010", PcDate); end
  endtask

  task automatic test_pre_redirect();
    PcStop = 1'b1; PreReDirAble = 1'b1; PreReDirPc = 32'h1c000108;
    tick();
    PreReDirAble = 1'b0;
    checks++; if (PcDate !== 32'h1c000108) begin errors++; $display("FAIL pre_pc got=%h exp=1c000108", PcDate); end
    checks++; if (PcMask !== 4'b1100) begin errors++; $display("FAIL pre_mask got=%b exp=1100", PcMask); end
    checks++; if (PcEpoch !== 3'd1) begin errors++; $display("FAIL pre_epoch got=%0d exp=1", PcEpoch); end
    tick();
    checks++; if (PcDate !== 32'h1c000108) begin errors++; $display("FAIL pre_stall_pc got=%h exp=1c000108", PcDate); end
    // BTB slot 1 lies before offset 2: no truncation, no target.
    BtbPredictAble = 1'b1; BtbPredictSlot = 2'd1; BtbPredictPc = 32'h1c000900;
    #1;
    checks++; if (PcMask !== 4'b1100) begin errors++; $display("FAIL btb_below_off_mask got=%b exp=1100", PcMask); end
    PcStop = 1'b0;
    tick();
    BtbPredictAble = 1'b0; PcStop = 1'b1;
    checks++; if (PcDate !== 32'h1c000110) begin errors++; $display("FAIL pre_seq_pc got=%h exp=1c000110", PcDate); end
  endtask

  task automatic test_btb();
    RobReDirAble = 1'b1; RobReDirPc = 32'h1c000010;
    tick();
    RobReDirAble = 1'b0;
    checks++; if (PcEpoch !== 3'd2) begin errors++; $display("FAIL rob_epoch got=%0d exp=2", PcEpoch); end
    BtbPredictAble = 1'b1; BtbPredictSlot = 2'd1; BtbPredictPc = 32'h1c000400;
    #1;
    checks++; if (PcMask !== 4'b0011) begin errors++; $display("FAIL btb_mask got=%b exp=0011", PcMask); end
    tick();
    checks++; if (PcDate !== 32'h1c000010) begin errors++; $display("FAIL btb_stall_pc got=%h exp=1c000010", PcDate); end
    PcStop = 1'b0;
    tick();
    BtbPredictAble = 1'b0; PcStop = 1'b1;
    checks++; if (PcDate !== 32'h1c000400) begin errors++; $display("FAIL btb_pc got=%h exp=1c000400", PcDate); end
  endtask

  task automatic test_rob_pre_same();
    RobReDirAble = 1'b1; RobReDirPc = 32'h1c002000;
    PreReDirAble = 1'b1; PreReDirPc = 32'h1c000500;
    tick();
    RobReDirAble = 1'b0; PreReDirAble = 1'b0;
    checks++; if (PcDate !== 32'h1c002000) begin errors++; $display("FAIL both_pc got=%h exp=1c002000", PcDate); end
    checks++; if (PcEpoch !== 3'd3) begin errors++; $display("FAIL both_epoch got=%0d exp=3", PcEpoch); end
  endtask

  task automatic test_idle();
    PcStop = 1'b0;
    RobReDirAble = 1'b1; RobIdleAble = 1'b1; RobReDirPc = 32'h1c000040;
    tick();
    RobReDirAble = 1'b0; RobIdleAble = 1'b0;
    PreReDirAble = 1'b1; PreReDirPc = 32'h1c000700;
    for (int i = 0; i < 5; i++) begin
      checks++; if (PcAble !== 1'b0) begin errors++; $display("FAIL idle_able[%0d] got=%b exp=0", i, PcAble); end
      checks++; if (PcDate !== 32'h1c000040) begin errors++; $display("FAIL idle_pc[%0d] got=%h exp=1c000040", i, PcDate); end
      if (i < 4) tick();
    end
    PreReDirAble = 1'b0; WakeUp = 1'b1;
    tick();
    WakeUp = 1'b0; PcStop = 1'b1;
    checks++; if (PcAble !== 1'b1) begin errors++; $display("FAIL wake_able got=%b exp=1", PcAble); end
    checks++; if (PcDate !== 32'h1c000040) begin errors++; $display("FAIL wake_pc got=%h exp=1c000040", PcDate); end
    checks++; if (PcEpoch !== 3'd4) begin errors++; $display("FAIL wake_epoch got=%0d exp=4", PcEpoch); end
  endtask

  task automatic test_adef();
    PreReDirAble = 1'b1; PreReDirPc = 32'h1c000102;
    tick();
    PreReDirAble = 1'b0;
    checks++; if (PcDate !== 32'h1c000100) begin errors++; $display("FAIL adef_pc got=%h exp=1c000100", PcDate); end
    checks++; if (PcAdef !== 1'b1) begin errors++; $display("FAIL adef_flag got=%b exp=1", PcAdef); end
    checks++; if (PcAble !== 1'b1) begin errors++; $display("FAIL adef_able got=%b exp=1", PcAble); end
    PcStop = 1'b0;
    tick();
    checks++; if (PcAble !== 1'b0) begin errors++; $display("FAIL fault_able got=%b exp=0", PcAble); end
    checks++; if (PcDate !== 32'h1c000100) begin errors++; $display("FAIL fault_pc got=%h exp=1c000100", PcDate); end
    PreReDirAble = 1'b1; PreReDirPc = 32'h1c000300;
    tick();
    PreReDirAble = 1'b0;
    tick();
    checks++; if (PcAble !== 1'b0) begin errors++; $display("FAIL fault_pre_able got=%b exp=0", PcAble); end
    checks++; if (PcDate !== 32'h1c000100) begin errors++; $display("FAIL fault_pre_pc got=%h exp=1c000100", PcDate); end
    checks++; if (PcEpoch !== 3'd5) begin errors++; $display("FAIL fault_epoch got=%0d exp=5", PcEpoch); end
    RobReDirAble = 1'b1; RobReDirPc = 32'h1c000200;
    tick();
    RobReDirAble = 1'b0; PcStop = 1'b1;
    checks++; if (PcAble !== 1'b1) begin errors++; $display("FAIL unfault_able got=%b exp=1", PcAble); end
    checks++; if (PcAdef !== 1'b0) begin errors++; $display("FAIL unfault_adef got=%b exp=0", PcAdef); end
    checks++; if (PcDate !== 32'h1c000200) begin errors++; $display("FAIL unfault_pc got=%h exp=1c000200", PcDate); end
  endtask

  task automatic test_btb_misaligned();
    BtbPredictAble = 1'b1; BtbPredictSlot = 2'd3; BtbPredictPc = 32'h1c000806;
    #1;
    checks++; if (PcMask !== 4'b1111) begin errors++; $display("FAIL btb3_mask got=%b exp=1111", PcMask); end
    PcStop = 1'b0;
    tick();
    BtbPredictAble = 1'b0; PcStop = 1'b1;
    checks++; if (PcDate !== 32'h1c000804) begin errors++; $display("FAIL btbmis_pc got=%h exp=1c000804", PcDate); end
    checks++; if (PcAdef !== 1'b1) begin errors++; $display("FAIL btbmis_adef got=%b exp=1", PcAdef); end
  endtask

  task automatic test_epoch_wrap();
    RobReDirAble = 1'b1; RobReDirPc = 32'h1c000000;
    tick();
    checks++; if (PcEpoch !== 3'd7) begin errors++; $display("FAIL epoch7 got=%0d exp=7", PcEpoch); end
    tick();
    RobReDirAble = 1'b0;
    checks++; if (PcEpoch !== 3'd0) begin errors++; $display("FAIL epoch_wrap got=%0d exp=0", PcEpoch); end
    checks++; if (PcAdef !== 1'b0) begin errors++; $display("FAIL wrap_adef got=%b exp=0", PcAdef); end
  endtask

  task automatic test_async_reset();
    PcStop = 1'b0;
    tick();
    #2 Rest = 1'b1;
    #1;
    checks++; if (PcAble !== 1'b0) begin errors++; $display("FAIL arst_able got=%b exp=0", PcAble); end
    checks++; if (PcDate !== 32'h1c000000) begin errors++; $display("FAIL arst_pc got=%h exp=1c000000", PcDate); end
    @(negedge Clk);
    Rest = 1'b0;
    PreReDirAble = 1'b1; PreReDirPc = 32'h1c000020;
    tick();
    PreReDirAble = 1'b0;
    checks++; if (PcAble !== 1'b0) begin errors++; $display("FAIL bootpre_able got=%b exp=0", PcAble); end
    checks++; if (PcDate !== 32'h1c000020) begin errors++; $display("FAIL bootpre_pc got=%h exp=1c000020", PcDate); end
    checks++; if (PcEpoch !== 3'd1) begin errors++; $display("FAIL bootpre_epoch got=%0d exp=1", PcEpoch); end
    tick();
    checks++; if (PcAble !== 1'b1) begin errors++; $display("FAIL reboot_able got=%b exp=1", PcAble); end
  endtask

  initial begin
    test_reset();
    test_pre_redirect();
    test_btb();
    test_rob_pre_same();
    test_idle();
    test_adef();
    test_btb_misaligned();
    test_epoch_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
